// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem two-master arbiter.
// Holds the FSM state enum, bus widths, the request bundle and the error read value.
package iomem_pkg;

    localparam int IOMEM_AW = 32;
    localparam int IOMEM_DW = 32;

    localparam logic [IOMEM_DW-1:0] IOMEM_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } iomem_state_e;

    typedef struct packed {
        logic [3:0]          wstrb;
        logic [IOMEM_AW-1:0] addr;
        logic [IOMEM_DW-1:0] wdata;
    } iomem_req_t;

endpackage

// File: rtl/iomem_watchdog.sv
// Transaction watchdog: counts enabled cycles, flags expiry at TIMEOUT-1.
// Ports: clk, resetn, clr (sync clear), en (count), expired (terminate now).
module iomem_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // TIMEOUT=0 disables the watchdog; keep a 1-bit counter so widths stay legal.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter for two iomem masters onto one registered peripheral port.
// Ports: m0_*/m1_* master side, iomem_* peripheral side, bus_err* timeout diagnostics.
module iomem_arbiter
    import iomem_pkg::*;
#(
    parameter int                  TIMEOUT   = 1024,
    parameter logic [IOMEM_DW-1:0] ERR_RDATA = IOMEM_ERR_RDATA
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                m0_valid,
    input  logic [3:0]          m0_wstrb,
    input  logic [IOMEM_AW-1:0] m0_addr,
    input  logic [IOMEM_DW-1:0] m0_wdata,
    output logic                m0_ready,
    output logic [IOMEM_DW-1:0] m0_rdata,

    input  logic                m1_valid,
    input  logic [3:0]          m1_wstrb,
    input  logic [IOMEM_AW-1:0] m1_addr,
    input  logic [IOMEM_DW-1:0] m1_wdata,
    output logic                m1_ready,
    output logic [IOMEM_DW-1:0] m1_rdata,

    output logic                iomem_valid,
    output logic [3:0]          iomem_wstrb,
    output logic [IOMEM_AW-1:0] iomem_addr,
    output logic [IOMEM_DW-1:0] iomem_wdata,
    input  logic                iomem_ready,
    input  logic [IOMEM_DW-1:0] iomem_rdata,

    output logic                bus_err,
    output logic                bus_err_master,
    output logic [IOMEM_AW-1:0] bus_err_addr,
    output logic                timeout_pulse,
    input  logic                err_clr
);

    iomem_state_e state_q, state_d;

    logic                last_grant;
    logic                gnt_q;
    logic                gnt_sel;
    logic                do_grant;
    logic                do_done;
    logic                do_tout;
    logic                wd_expired;
    iomem_req_t          m0_req, m1_req, sel_req, req_q;
    logic [IOMEM_DW-1:0] rdata_q;

    assign m0_req = '{wstrb: m0_wstrb, addr: m0_addr, wdata: m0_wdata};
    assign m1_req = '{wstrb: m1_wstrb, addr: m1_addr, wdata: m1_wdata};

    // On a tie the master that did not win last time gets the bus.
    assign gnt_sel = m1_valid & (~m0_valid | ~last_grant);
    assign sel_req = gnt_sel ? m1_req : m0_req;

    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_done  = 1'b0;
        do_tout  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    do_grant = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (iomem_ready) begin
                    do_done = 1'b1;
                    state_d = RESP;
                end else if (wd_expired) begin
                    do_tout = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    iomem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (do_grant),
        .en      (state_q == BUSY),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant  <= 1'b1;
            gnt_q       <= 1'b0;
            req_q       <= '0;
            iomem_valid <= 1'b0;
            rdata_q     <= '0;
        end else begin
            if (do_grant) begin
                last_grant  <= gnt_sel;
                gnt_q       <= gnt_sel;
                req_q       <= sel_req;
                iomem_valid <= 1'b1;
            end
            if (do_done) begin
                rdata_q     <= iomem_rdata;
                iomem_valid <= 1'b0;
            end
            if (do_tout) begin
                rdata_q     <= ERR_RDATA;
                iomem_valid <= 1'b0;
            end
        end
    end

    // A timeout in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_err        <= 1'b0;
            bus_err_master <= 1'b0;
            bus_err_addr   <= '0;
            timeout_pulse  <= 1'b0;
        end else begin
            timeout_pulse <= do_tout;
            if (do_tout) begin
                bus_err        <= 1'b1;
                bus_err_master <= gnt_q;
                bus_err_addr   <= req_q.addr;
            end else if (err_clr) begin
                bus_err        <= 1'b0;
                bus_err_master <= 1'b0;
                bus_err_addr   <= '0;
            end
        end
    end

    assign iomem_wstrb = req_q.wstrb;
    assign iomem_addr  = req_q.addr;
    assign iomem_wdata = req_q.wdata;

    assign m0_ready = (state_q == RESP) && !gnt_q;
    assign m1_ready = (state_q == RESP) &&  gnt_q;
    assign m0_rdata = m0_ready ? rdata_q : '0;
    assign m1_rdata = m1_ready ? rdata_q : '0;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench for iomem_arbiter with TIMEOUT=8.
// Covers single read, tie alternation, write path, watchdog, async reset.
module tb_iomem_arbiter;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        bus_err, bus_err_master, timeout_pulse, err_clr;
    logic [31:0] bus_err_addr;

    logic        auto_rdy;
    logic        man_rdy;
    logic [31:0] man_rdata;

    int checks = 0;
    int errors = 0;

    // Auto mode: peripheral answers in the first BUSY cycle, echoing the address.
    assign iomem_ready = auto_rdy ? iomem_valid : man_rdy;
    assign iomem_rdata = auto_rdy ? iomem_addr : man_rdata;

    iomem_arbiter #(
        .TIMEOUT   (8),
        .ERR_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .m0_valid       (m0_valid),
        .m0_wstrb       (m0_wstrb),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_ready       (m0_ready),
        .m0_rdata       (m0_rdata),
        .m1_valid       (m1_valid),
        .m1_wstrb       (m1_wstrb),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_ready       (m1_ready),
        .m1_rdata       (m1_rdata),
        .iomem_valid    (iomem_valid),
        .iomem_wstrb    (iomem_wstrb),
        .iomem_addr     (iomem_addr),
        .iomem_wdata    (iomem_wdata),
        .iomem_ready    (iomem_ready),
        .iomem_rdata    (iomem_rdata),
        .bus_err        (bus_err),
        .bus_err_master (bus_err_master),
        .bus_err_addr   (bus_err_addr),
        .timeout_pulse  (timeout_pulse),
        .err_clr        (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_time_limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        m0_valid  = 1'b0;
        m1_valid  = 1'b0;
        m0_wstrb  = 4'h0;
        m1_wstrb  = 4'h0;
        m0_addr   = 32'h0;
        m1_addr   = 32'h0;
        m0_wdata  = 32'h0;
        m1_wdata  = 32'h0;
        err_clr   = 1'b0;
        auto_rdy  = 1'b0;
        man_rdy   = 1'b0;
        man_rdata = 32'h0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clr_inputs();
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        int n;
        int cyc;
        logic [31:0] exp_a;

        do_reset();

        chk("rst_iomem_valid", 32'(iomem_valid), 32'h0);
        chk("rst_m0_ready", 32'(m0_ready), 32'h0);
        chk("rst_m1_ready", 32'(m1_ready), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_iomem_addr", iomem_addr, 32'h0);

        // Single m0 read, ready at k=2.
        m0_valid = 1'b1;
        m0_addr  = 32'h0300_0004;
        step();
        chk("rd_valid_c1", 32'(iomem_valid), 32'h1);
        chk("rd_addr_c1", iomem_addr, 32'h0300_0004);
        chk("rd_wstrb_c1", 32'(iomem_wstrb), 32'h0);
        chk("rd_m0_ready_c1", 32'(m0_ready), 32'h0);
        step();
        chk("rd_valid_c2", 32'(iomem_valid), 32'h1);
        man_rdy   = 1'b1;
        man_rdata = 32'h0000_00A5;
        step();
        chk("rd_m0_ready_c3", 32'(m0_ready), 32'h1);
        chk("rd_m0_rdata_c3", m0_rdata, 32'h0000_00A5);
        chk("rd_m1_ready_c3", 32'(m1_ready), 32'h0);
        chk("rd_m1_rdata_c3", m1_rdata, 32'h0);
        chk("rd_valid_c3", 32'(iomem_valid), 32'h0);
        m0_valid = 1'b0;
        man_rdy  = 1'b0;
        step();
        chk("rd_m0_ready_c4", 32'(m0_ready), 32'h0);
        chk("rd_idle_c4", 32'(iomem_valid), 32'h0);

        // Tie after reset: m0 first, then strict alternation.
        do_reset();
        m0_valid = 1'b1;
        m0_addr  = 32'h0300_0100;
        m1_valid = 1'b1;
        m1_addr  = 32'h0300_0200;
        auto_rdy = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 4 && cyc < 40) begin
            step();
            cyc++;
            if (m0_ready || m1_ready) begin
                exp_a = (n % 2 == 1) ? 32'h0300_0200 : 32'h0300_0100;
                chk("alt_who", 32'(m1_ready), 32'(n % 2));
                chk("alt_other", 32'(m0_ready & m1_ready), 32'h0);
                chk("alt_rdata", m1_ready ? m1_rdata : m0_rdata, exp_a);
                n++;
            end
        end
        chk("alt_count", 32'(n), 32'd4);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        auto_rdy = 1'b0;
        step();
        step();

        // m1 write held through a three-cycle wait.
        m1_valid = 1'b1;
        m1_addr  = 32'h0700_0000;
        m1_wstrb = 4'hF;
        m1_wdata = 32'h1234_5678;
        step();
        chk("wr_valid_c1", 32'(iomem_valid), 32'h1);
        chk("wr_addr_c1", iomem_addr, 32'h0700_0000);
        chk("wr_wstrb_c1", 32'(iomem_wstrb), 32'hF);
        chk("wr_wdata_c1", iomem_wdata, 32'h1234_5678);
        step();
        step();
        chk("wr_valid_c3", 32'(iomem_valid), 32'h1);
        chk("wr_addr_c3", iomem_addr, 32'h0700_0000);
        chk("wr_wstrb_c3", 32'(iomem_wstrb), 32'hF);
        chk("wr_wdata_c3", iomem_wdata, 32'h1234_5678);
        man_rdy   = 1'b1;
        man_rdata = 32'h0000_0055;
        step();
        chk("wr_m1_ready", 32'(m1_ready), 32'h1);
        chk("wr_m1_rdata", m1_rdata, 32'h0000_0055);
        chk("wr_m0_ready", 32'(m0_ready), 32'h0);
        m1_valid = 1'b0;
        m1_wstrb = 4'h0;
        man_rdy  = 1'b0;
        step();

        // Watchdog: BUSY entered at c1, response at c9.
        m0_valid = 1'b1;
        m0_addr  = 32'h0600_0000;
        step();
        chk("to_valid_c1", 32'(iomem_valid), 32'h1);
        for (int i = 2; i <= 8; i++) begin
            step();
            chk("to_early_ready", 32'(m0_ready), 32'h0);
            chk("to_early_pulse", 32'(timeout_pulse), 32'h0);
        end
        chk("to_early_err", 32'(bus_err), 32'h0);
        step();
        chk("to_m0_ready", 32'(m0_ready), 32'h1);
        chk("to_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("to_m1_ready", 32'(m1_ready), 32'h0);
        chk("to_pulse", 32'(timeout_pulse), 32'h1);
        chk("to_bus_err", 32'(bus_err), 32'h1);
        chk("to_err_master", 32'(bus_err_master), 32'h0);
        chk("to_err_addr", bus_err_addr, 32'h0600_0000);
        chk("to_valid_off", 32'(iomem_valid), 32'h0);
        m0_valid = 1'b0;
        step();
        chk("to_pulse_off", 32'(timeout_pulse), 32'h0);
        chk("to_err_sticky", 32'(bus_err), 32'h1);
        chk("to_addr_sticky", bus_err_addr, 32'h0600_0000);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_bus_err", 32'(bus_err), 32'h0);
        chk("clr_err_master", 32'(bus_err_master), 32'h0);
        chk("clr_err_addr", bus_err_addr, 32'h0);

        // Async reset mid-BUSY, then pending m1 granted normally.
        m0_valid = 1'b1;
        m0_addr  = 32'h0100_0040;
        m0_wstrb = 4'h3;
        m0_wdata = 32'hCAFE_0001;
        step();
        chk("ar_busy_valid", 32'(iomem_valid), 32'h1);
        chk("ar_busy_addr", iomem_addr, 32'h0100_0040);
        #2;
        resetn   = 1'b0;
        m0_valid = 1'b0;
        m0_wstrb = 4'h0;
        m1_valid = 1'b1;
        m1_addr  = 32'h0200_0010;
        #1;
        chk("ar_valid", 32'(iomem_valid), 32'h0);
        chk("ar_addr", iomem_addr, 32'h0);
        chk("ar_wstrb", 32'(iomem_wstrb), 32'h0);
        chk("ar_wdata", iomem_wdata, 32'h0);
        chk("ar_readys", 32'({m0_ready, m1_ready}), 32'h0);
        chk("ar_err", 32'({bus_err, bus_err_master, timeout_pulse}), 32'h0);
        step();
        chk("ar_hold_valid", 32'(iomem_valid), 32'h0);
        resetn = 1'b1;
        step();
        chk("ar_m1_valid", 32'(iomem_valid), 32'h1);
        chk("ar_m1_addr", iomem_addr, 32'h0200_0010);
        man_rdy   = 1'b1;
        man_rdata = 32'h0000_0077;
        step();
        chk("ar_m1_ready", 32'(m1_ready), 32'h1);
        chk("ar_m1_rdata", m1_rdata, 32'h0000_0077);
        chk("ar_m0_ready", 32'(m0_ready), 32'h0);
        m1_valid = 1'b0;
        man_rdy  = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
